// File: rtl/alu_share_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_arb_pkg
// Shared definitions for the two-requester LUI/SLT/SLTU arbiter:
//   - aluc operation encodings used by requesters and the datapath
//   - requester id constants carried on rsp_id
//   - the enum tracking which requester was granted last
// No ports (package).
// ---------------------------------------------------------------------------
package alu_share_arb_pkg;

    // Operation encodings on reqN_aluc. Both 00 and 01 select LUI.
    localparam logic [1:0] ALUC_LUI     = 2'b00;
    localparam logic [1:0] ALUC_LUI_ALT = 2'b01;
    localparam logic [1:0] ALUC_SLTU    = 2'b10;
    localparam logic [1:0] ALUC_SLT     = 2'b11;

    // Requester ids as they appear on rsp_id.
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    // Last-granted requester. Reset value LRG_REQ1 lets requester 0 win the
    // first contention.
    typedef enum logic {
        LRG_REQ0 = 1'b0,
        LRG_REQ1 = 1'b1
    } lrg_e;

endpackage

// File: rtl/alu_share_arb_cmp_lui_unit.sv
// ---------------------------------------------------------------------------
// cmp_lui_unit
// Purely combinational shared datapath: LUI, SLTU and SLT.
// Ports:
//   a    [DW-1:0] in   first operand (ignored for LUI)
//   b    [DW-1:0] in   second operand
//   aluc [1:0]    in   operation select (see alu_share_arb_pkg)
//   r    [DW-1:0] out  result; compare results occupy bit 0 only
// ---------------------------------------------------------------------------
module cmp_lui_unit
    import alu_share_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [1:0]    aluc,
    output logic [DW-1:0] r
);

    logic [DW-1:0] luiVal;
    logic          ltUnsigned;
    logic          ltSigned;

    // LUI places the low half-word of b in the upper 16 bits of a 32-bit
    // word, so the shift is done on a 32-bit value and then sized to DW.
    assign luiVal = DW'({b[15:0], 16'h0000});

    // Signed less-than reuses the unsigned comparator: when signs differ the
    // negative operand (a's sign bit set) is the smaller one, otherwise the
    // two's-complement order matches the unsigned order.
    assign ltUnsigned = (a < b);
    assign ltSigned   = (a[DW-1] != b[DW-1]) ? a[DW-1] : ltUnsigned;

    // Select the result for the requested operation; comparisons return 0/1
    // with all upper bits cleared.
    always_comb begin
        r = '0;
        case (aluc)
            ALUC_LUI, ALUC_LUI_ALT: r    = luiVal;
            ALUC_SLTU:              r[0] = ltUnsigned;
            ALUC_SLT:               r[0] = ltSigned;
            default:                r    = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb
// Two requesters share one LUI/SLT/SLTU datapath through a round-robin
// arbiter. The granted operation is evaluated combinationally and captured
// in a single result register (1-cycle latency, 1 op/cycle throughput).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid/a/b/aluc        requester N operation (held until accepted)
//   reqN_ready                 requester N accepted this cycle
//   rsp_valid/rsp_id/rsp_data  held result, issuing requester, result value
//   rsp_ready                  consumer takes the result this cycle
//   gnt0_cnt, gnt1_cnt [CW]    per-requester acceptance counters, present
//                              only when ALU_SHARE_ARB_CNT_EN is defined
// Optional feature macro: ALU_SHARE_ARB_CNT_EN
// ---------------------------------------------------------------------------
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [1:0]    req0_aluc,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [1:0]    req1_aluc,
    output logic          req1_ready,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    input  logic          rsp_ready
`ifdef ALU_SHARE_ARB_CNT_EN
    ,
    output logic [CW-1:0] gnt0_cnt,
    output logic [CW-1:0] gnt1_cnt
`endif
);

    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    lrg_e          lrg_q, lrg_d;

    logic          regFree;
    logic          gnt0;
    logic          gnt1;
    logic          accept;
    logic          gntId;
    logic [DW-1:0] opA;
    logic [DW-1:0] opB;
    logic [1:0]    opAluc;
    logic [DW-1:0] aluR;

    // Grant decision. The result register can take a new value when it is
    // empty or being drained this cycle. With a single valid requester it
    // simply wins; with both valid the one that was not granted last wins.
    // Reset suppresses all grants so nothing is accepted while rst_n is low.
    always_comb begin
        regFree = !rsp_valid_q || rsp_ready;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        if (rst_n && regFree) begin
            if (req0_valid && req1_valid) begin
                if (lrg_q == LRG_REQ1) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
        accept = gnt0 | gnt1;
        gntId  = gnt1 ? REQ_ID1 : REQ_ID0;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Steer the granted requester's operands into the shared datapath.
    assign opA    = gnt1 ? req1_a    : req0_a;
    assign opB    = gnt1 ? req1_b    : req0_b;
    assign opAluc = gnt1 ? req1_aluc : req0_aluc;

    cmp_lui_unit #(
        .DW(DW)
    ) u_cmp_lui_unit (
        .a   (opA),
        .b   (opB),
        .aluc(opAluc),
        .r   (aluR)
    );

    // Result register next state. An acceptance always loads a fresh result
    // (even while the old one is draining, giving back-to-back throughput);
    // otherwise a drain empties the register; otherwise everything holds.
    // The round-robin pointer only moves on acceptance.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        lrg_d       = lrg_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gntId;
            rsp_data_d  = aluR;
            lrg_d       = lrg_e'(gntId);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset; reset discards any held result
    // and arms the pointer so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= REQ_ID0;
            rsp_data_q  <= '0;
            lrg_q       <= LRG_REQ1;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            lrg_q       <= lrg_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

`ifdef ALU_SHARE_ARB_CNT_EN
    logic [CW-1:0] gnt0_cnt_q, gnt0_cnt_d;
    logic [CW-1:0] gnt1_cnt_q, gnt1_cnt_d;

    // Acceptance counters; they wrap naturally at 2^CW.
    always_comb begin
        gnt0_cnt_d = gnt0_cnt_q;
        gnt1_cnt_d = gnt1_cnt_q;
        if (gnt0) begin
            gnt0_cnt_d = gnt0_cnt_q + CW'(1);
        end
        if (gnt1) begin
            gnt1_cnt_d = gnt1_cnt_q + CW'(1);
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt0_cnt_q <= '0;
            gnt1_cnt_q <= '0;
        end else begin
            gnt0_cnt_q <= gnt0_cnt_d;
            gnt1_cnt_q <= gnt1_cnt_d;
        end
    end

    assign gnt0_cnt = gnt0_cnt_q;
    assign gnt1_cnt = gnt1_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arb
// Directed and randomized checks of alu_share_arb against a behavioural
// model of the arbitration rules and the LUI/SLT/SLTU arithmetic.
// Counter checks are compiled in when ALU_SHARE_ARB_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_alu_share_arb;

    localparam int DW = 32;
`ifdef ALU_SHARE_ARB_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic [1:0]    req0_aluc;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic [1:0]    req1_aluc;
    logic          req1_ready;
    logic          rsp_valid;
    logic          rsp_id;
    logic [DW-1:0] rsp_data;
    logic          rsp_ready;
`ifdef ALU_SHARE_ARB_CNT_EN
    logic [CW-1:0] gnt0_cnt;
    logic [CW-1:0] gnt1_cnt;
`endif

    int assertCount = 0;
    int failCount   = 0;

    // Behavioural model state: what the result register should hold, who
    // was granted last, and how many acceptances each requester has had.
    bit            mValid;
    bit            mId;
    logic [DW-1:0] mData;
    int            lastGnt;
    int            mCnt0;
    int            mCnt1;
    bit            acc0;
    bit            acc1;

    always #5 clk = ~clk;

    alu_share_arb #(
        .DW(DW),
        .CW(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_aluc (req0_aluc),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_aluc (req1_aluc),
        .req1_ready(req1_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
`ifdef ALU_SHARE_ARB_CNT_EN
        ,
        .gnt0_cnt  (gnt0_cnt),
        .gnt1_cnt  (gnt1_cnt)
`endif
    );

    // Reference arithmetic written directly from the operation definitions.
    function automatic logic [DW-1:0] refAlu(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b,
                                             input logic [1:0] c);
        logic [DW-1:0] res;
        res = '0;
        if (c == 2'd0 || c == 2'd1) begin
            res = {b[15:0], 16'h0000};
        end else if (c == 2'd2) begin
            res = (a < b) ? 1 : 0;
        end else begin
            res = ($signed(a) < $signed(b)) ? 1 : 0;
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] randOperand();
        logic [DW-1:0] v;
        case ($urandom_range(0, 3))
            0: v = 32'h8000_0000;
            1: v = 32'h7FFF_FFFF;
            2: v = DW'($urandom_range(0, 20)) - 32'd10;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: check readys against the arbitration rules, let the
    // edge happen, advance the model, then check the result register.
    task automatic applyStimulus();
        bit g0;
        bit g1;
        bit regFree;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        regFree = !mValid || rsp_ready;
        if (rst_n && regFree) begin
            if (req0_valid && req1_valid) begin
                if (lastGnt == 1) g0 = 1'b1;
                else              g1 = 1'b1;
            end else if (req0_valid) begin
                g0 = 1'b1;
            end else if (req1_valid) begin
                g1 = 1'b1;
            end
        end
        checkOutput("req0_ready", DW'(req0_ready), DW'(g0));
        checkOutput("req1_ready", DW'(req1_ready), DW'(g1));
        @(posedge clk);
        if (!rst_n) begin
            mValid  = 1'b0;
            mId     = 1'b0;
            mData   = '0;
            lastGnt = 1;
            mCnt0   = 0;
            mCnt1   = 0;
        end else if (g0 || g1) begin
            mValid  = 1'b1;
            mId     = g1;
            mData   = g1 ? refAlu(req1_a, req1_b, req1_aluc)
                         : refAlu(req0_a, req0_b, req0_aluc);
            lastGnt = g1 ? 1 : 0;
            if (g0) mCnt0++;
            if (g1) mCnt1++;
        end else if (rsp_ready) begin
            mValid = 1'b0;
        end
        acc0 = g0;
        acc1 = g1;
        #1;
        checkOutput("rsp_valid", DW'(rsp_valid), DW'(mValid));
        checkOutput("rsp_id", DW'(rsp_id), DW'(mId));
        checkOutput("rsp_data", rsp_data, mData);
`ifdef ALU_SHARE_ARB_CNT_EN
        checkOutput("gnt0_cnt", DW'(gnt0_cnt), DW'(mCnt0 % (1 << CW)));
        checkOutput("gnt1_cnt", DW'(gnt1_cnt), DW'(mCnt1 % (1 << CW)));
`endif
    endtask

    task automatic setReq(input int id, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [1:0] c);
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_aluc = c;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_aluc = c;
        end
    endtask

    // Issue a single operation on one requester, check its result against a
    // hand-computed constant, then drain the result register.
    task automatic runOne(input string tag, input int id, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [1:0] c,
                          input logic [DW-1:0] expected);
        rsp_ready = 1'b1;
        setReq(id, a, b, c);
        applyStimulus();
        checkOutput(tag, rsp_data, expected);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        applyStimulus();
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_aluc = 2'b00;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_aluc = 2'b00;
        rsp_ready  = 1'b0;
        mValid = 1'b0; mId = 1'b0; mData = '0; lastGnt = 1; mCnt0 = 0; mCnt1 = 0;

        // Reset with both requesters valid: no acceptance may happen.
        applyStimulus();
        applyStimulus();
        checkOutput("reset_valid", DW'(rsp_valid), '0);
        checkOutput("reset_data", rsp_data, '0);
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        applyStimulus();

        // LUI on requester 0 with a ignored.
        runOne("lui_data", 0, 32'hDEAD_BEEF, 32'h0000_1234, 2'b00, 32'h1234_0000);

        // Fresh reset, then both requesters valid every cycle: strict
        // alternation 0,1,0,... with SLT on req0 and SLTU on req1.
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        setReq(0, 32'hFFFF_FFFF, 32'h0000_0001, 2'b11);
        setReq(1, 32'hFFFF_FFFF, 32'h0000_0001, 2'b10);
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput("rr_id", DW'(rsp_id), DW'(i % 2));
            checkOutput("rr_data", rsp_data, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        applyStimulus();

        // Stall: hold a result for three cycles with both requesters waiting,
        // then release and expect an acceptance in the same cycle.
        setReq(0, 32'h0, 32'h0000_ABCD, 2'b01);
        applyStimulus();
        rsp_ready = 1'b0;
        setReq(0, 32'h5, 32'h6, 2'b10);
        setReq(1, 32'h9, 32'h3, 2'b11);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("stall_data", rsp_data, 32'hABCD_0000);
            checkOutput("stall_ready0", DW'(req0_ready), '0);
        end
        rsp_ready = 1'b1;
        applyStimulus();
        checkOutput("release_accept", DW'(req0_ready | req1_ready), 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        applyStimulus();

        // Comparison boundary cases.
        runOne("slt_min_max", 1, 32'h8000_0000, 32'h7FFF_FFFF, 2'b11, 32'd1);
        runOne("slt_equal", 0, 32'h0000_0005, 32'h0000_0005, 2'b11, 32'd0);
        runOne("sltu_cross", 1, 32'h7FFF_FFFF, 32'h8000_0000, 2'b10, 32'd1);
        runOne("slt_pos_neg", 0, 32'h0000_0001, 32'hFFFF_FFFF, 2'b11, 32'd0);

        // Reset while a result is held discards it and re-arms requester 0.
        rsp_ready = 1'b0;
        setReq(1, 32'h0, 32'h0000_7777, 2'b00);
        applyStimulus();
        req1_valid = 1'b0;
        rst_n = 1'b0;
        applyStimulus();
        checkOutput("midrst_valid", DW'(rsp_valid), '0);
        checkOutput("midrst_data", rsp_data, '0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        setReq(0, 32'h1, 32'h2, 2'b10);
        setReq(1, 32'h2, 32'h1, 2'b10);
        applyStimulus();
        checkOutput("midrst_first_gnt", DW'(rsp_id), '0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        applyStimulus();

`ifdef ALU_SHARE_ARB_CNT_EN
        // Counter wrap: 17 acceptances on requester 0 with CW=4.
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        setReq(0, 32'h3, 32'h4, 2'b10);
        for (int i = 0; i < 17; i++) begin
            applyStimulus();
        end
        checkOutput("cnt0_wrap", DW'(gnt0_cnt), 32'd1);
        checkOutput("cnt1_wrap", DW'(gnt1_cnt), 32'd0);
        req0_valid = 1'b0;
        applyStimulus();
`endif

        // Randomized traffic: requesters hold operations until accepted,
        // the consumer back-pressures at random, occasional resets.
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid && $urandom_range(0, 9) < 6) begin
                req0_a = randOperand();
                req0_b = ($urandom_range(0, 7) == 0) ? req0_a : randOperand();
                setReq(0, req0_a, req0_b, 2'($urandom_range(0, 3)));
            end
            if (!req1_valid && $urandom_range(0, 9) < 6) begin
                req1_a = randOperand();
                req1_b = ($urandom_range(0, 7) == 0) ? req1_a : randOperand();
                setReq(1, req1_a, req1_b, 2'($urandom_range(0, 3)));
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            rst_n = ($urandom_range(0, 59) != 0);
            applyStimulus();
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter: DW, default 32, operand/result width.
REQ-002 Parameter: CW, default 16, width of optional grant counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_a / req0_b  input  DW  requester 0 operands.
REQ-007 req0_aluc  input  2  requester 0 op: 00/01 LUI, 10 SLTU, 11 SLT.
REQ-008 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-009 req1_valid, req1_a, req1_b, req1_aluc, req1_ready  same as REQ-005..REQ-008 for requester 1.
REQ-010 rsp_valid  output  1  result register holds a valid result.
REQ-011 rsp_id  output  1  requester that issued the held result.
REQ-012 rsp_data  output  DW  held result.
REQ-013 rsp_ready  input  1  consumer takes the result this cycle.

Function
REQ-014 Transfer on a port when valid and ready are both high in the same cycle; a requester holds valid and operands stable until accepted.
REQ-015 Result register is free when rsp_valid=0 or (rsp_valid=1 and rsp_ready=1); readys are driven only when the register is free.
REQ-016 At most one requester accepted per cycle; ready is combinational from valids, free condition and the round-robin pointer.
REQ-017 Only one valid: that requester is granted.
REQ-018 Both valid: grant the requester that is not the last granted (pointer lrg); lrg updates to the granted id on every acceptance.
REQ-019 Shared datapath evaluated combinationally on the granted operands; result captured in the result register on acceptance; latency exactly 1 cycle (accept at cycle N, rsp_valid=1 at N+1).
REQ-020 LUI: rsp_data = {b[15:0], 16'h0000}; a ignored.
REQ-021 SLTU: rsp_data = 1 if a < b unsigned, else 0; bits [DW-1:1] zero.
REQ-022 SLT: rsp_data = 1 if a < b two's-complement, else 0; sign differs -> result from sign of a; signs equal -> unsigned compare.
REQ-023 rsp_valid clears after rsp_ready handshake unless a new acceptance occurs the same cycle (back-to-back throughput 1 op/cycle).
REQ-024 rsp_valid=1 and rsp_ready=0: result, id and rsp_valid held; both readys low.
REQ-025 Neither valid while register free: rsp_valid goes or stays 0; lrg unchanged.

Reset
REQ-026 rst_n=0 at a rising edge: rsp_valid=0, rsp_id=0, rsp_data=0, lrg=1 (requester 0 wins first contention), counters 0.
REQ-027 Reset mid-operation discards any held result; no acceptance occurs in a cycle where rst_n=0 (readys forced 0).

Configuration
REQ-028 Macro ALU_SHARE_ARB_CNT_EN defined: outputs gnt0_cnt, gnt1_cnt (CW each) count acceptances per requester, wrap modulo 2^CW.
REQ-029 Macro undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-030 Shared package holds aluc encodings (ALUC_LUI, ALUC_SLTU, ALUC_SLT) and requester id constants.
REQ-031 One sub-module cmp_lui_unit: combinational LUI/SLT/SLTU datapath (a, b, aluc -> r); the arbiter instantiates it once.

Verification
REQ-032 Reset, then req0 valid, aluc=00, b=0x00001234 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0x12340000.
REQ-033 Both valid every cycle, rsp_ready=1, after reset -> grants 0,1,0,1...; ops SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0.
REQ-034 rsp_ready=0 for 3 cycles with result held -> rsp_* stable, req0_ready=req1_ready=0; release -> next op accepted same cycle.
REQ-035 SLT a=0x80000000 b=0x7FFFFFFF -> 1; a=b=0x5 -> 0; SLTU a=0x7FFFFFFF b=0x80000000 -> 1.
REQ-036 rst_n=0 while rsp_valid=1 -> next cycle rsp_valid=0, rsp_data=0; first contention after reset grants requester 0.
REQ-037 With ALU_SHARE_ARB_CNT_EN, CW=4: 17 accepts on req0 -> gnt0_cnt=1, gnt1_cnt=0.
